reg_f_dma: RTL and testbench

Sequencing initiator for the reg_f register file: drives its IN/EN/WR/SEL pins and reads its OUT.
- Load mode: streams a block of words from a valid/ready source into consecutive registers.
- Dump mode: reads consecutive registers out to a valid/ready sink.
- Used for register-file init, context save/restore and debug readout.

---
 rtl/reg_f_dma_pkg.sv | 22 ++
 rtl/reg_f_dma_addr.sv | 56 +++++
 rtl/reg_f_dma.sv | 132 +++++++++++++
 tb/tb_reg_f_dma.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_f_dma_pkg.sv
// Shared definitions for the reg_f sequencing initiator: FSM states,
// transfer-mode encodings and the register-index width helper.
package reg_f_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_OUT  = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  localparam logic MODE_LOAD = 1'b1;
  localparam logic MODE_DUMP = 1'b0;

  // Register-index width; a one-entry file still gets a 1-bit index.
  function automatic int addr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/reg_f_dma_addr.sv
// Wrapping register-index counter plus remaining-word counter for one
// transfer. load_i latches the first index and the clamped word count;
// step_i advances both. last_o flags the final word of the transfer.
module reg_f_dma_addr
  import reg_f_dma_pkg::*;
#(
  parameter  int SIZE = 8,
  localparam int AW   = addr_width(SIZE),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic [CW-1:0] count_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam logic [AW-1:0] ADDR_MAX  = AW'(SIZE - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(SIZE);

  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] rem_q, rem_d;

  // Next index/count: latch on load (count clamped to SIZE), advance on step.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned, which would infer a latch.
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      addr_d = base_i;
      rem_d  = (count_i > COUNT_MAX) ? COUNT_MAX : count_i;
    end else if (step_i) begin
      addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + AW'(1);
      rem_d  = rem_q - CW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == CW'(1));

endmodule

// File: rtl/reg_f_dma.sv
// Sequencing initiator for the reg_f register file. Load mode streams words
// from a valid/ready source into consecutive registers; dump mode reads
// consecutive registers out to a valid/ready sink. Indices wrap at SIZE.
module reg_f_dma
  import reg_f_dma_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int SIZE   = 8,
  parameter  int RD_LAT = 1,
  localparam int AW     = addr_width(SIZE),
  localparam int CW     = AW + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             MODE,
  input  logic [AW-1:0]    BASE,
  input  logic [CW-1:0]    COUNT,
  output logic             BUSY,
  output logic             DONE,
  input  logic [WIDTH-1:0] S_DATA,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] RF_IN,
  output logic             RF_EN,
  output logic             RF_WR,
  output logic [AW-1:0]    RF_SEL,
  input  logic [WIDTH-1:0] RF_OUT
);

  state_e           state_q, state_d;
  logic             ctr_load, ctr_step, ctr_last;
  logic             capture;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] m_data_q;

  reg_f_dma_addr #(.SIZE(SIZE)) u_addr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .load_i  (ctr_load),
    .base_i  (BASE),
    .count_i (COUNT),
    .step_i  (ctr_step),
    .addr_o  (addr),
    .last_o  (ctr_last)
  );

  // Next-state and per-state reg_f / stream controls.
  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_step = 1'b0;
    capture  = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    S_READY  = 1'b0;
    M_VALID  = 1'b0;
    RF_EN    = 1'b0;
    RF_WR    = 1'b0;
    RF_IN    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          ctr_load = 1'b1;
          if (COUNT == '0)              state_d = ST_FIN;
          else if (MODE == MODE_LOAD)   state_d = ST_LOAD;
          else                          state_d = ST_RD_ADDR;
        end
      end
      ST_LOAD: begin
        BUSY    = 1'b1;
        S_READY = 1'b1;
        if (S_VALID) begin
          // The write lands at the same edge that completes the handshake.
          RF_EN    = 1'b1;
          RF_WR    = 1'b1;
          RF_IN    = S_DATA;
          ctr_step = 1'b1;
          if (ctr_last) state_d = ST_FIN;
        end
      end
      ST_RD_ADDR: begin
        BUSY  = 1'b1;
        RF_EN = 1'b1;
        if (RD_LAT == 0) begin
          capture = 1'b1;
          state_d = ST_RD_OUT;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        BUSY    = 1'b1;
        RF_EN   = 1'b1;
        capture = 1'b1;
        state_d = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        BUSY    = 1'b1;
        M_VALID = 1'b1;
        if (M_READY) begin
          ctr_step = 1'b1;
          state_d  = ctr_last ? ST_FIN : ST_RD_ADDR;
        end
      end
      ST_FIN: begin
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Dump data holding register; stays stable while the sink stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       m_data_q <= '0;
    else if (capture) m_data_q <= RF_OUT;
  end

  assign M_DATA = m_data_q;
  assign RF_SEL = addr;

endmodule

// File: tb/tb_reg_f_dma.sv
// Bench for reg_f_dma driving a behavioural reg_f. Expected writes, dump
// words and DONE pulses are queued when each transfer is issued; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_reg_f_dma;
  import reg_f_dma_pkg::*;

  localparam int WIDTH  = 4;
  localparam int SIZE   = 8;
  localparam int RD_LAT = 1;
  localparam int AW     = 3;
  localparam int CW     = 4;
  localparam int BUDGET = 400;
  localparam logic [WIDTH-1:0] INIT_VALS [SIZE] =
    '{4'h5, 4'h9, 4'h2, 4'hE, 4'h7, 4'h0, 4'hB, 4'h3};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, mode;
  logic [AW-1:0]    dma_base;
  logic [CW-1:0]    dma_count;
  logic             busy, done;
  logic [WIDTH-1:0] s_data;
  logic             s_valid, s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid, m_ready;
  logic [WIDTH-1:0] rf_in, rf_out;
  logic             rf_en, rf_wr;
  logic [AW-1:0]    rf_sel;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rf_en_cnt = 0;

  logic [WIDTH-1:0] model_mem [SIZE];
  logic [WIDTH-1:0] stim_words [$];
  int               exp_wr_sel_q [$];
  logic [WIDTH-1:0] exp_wr_data_q [$];
  logic [WIDTH-1:0] exp_rd_q [$];
  int               exp_done_q [$];
  bit               spacing_en = 1'b0;

  reg_f_dma #(.WIDTH(WIDTH), .SIZE(SIZE), .RD_LAT(RD_LAT)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .BASE(dma_base),
    .COUNT(dma_count), .BUSY(busy), .DONE(done), .S_DATA(s_data),
    .S_VALID(s_valid), .S_READY(s_ready), .M_DATA(m_data), .M_VALID(m_valid),
    .M_READY(m_ready), .RF_IN(rf_in), .RF_EN(rf_en), .RF_WR(rf_wr),
    .RF_SEL(rf_sel), .RF_OUT(rf_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural reg_f: synchronous write, registered read when RD_LAT=1.
  logic [WIDTH-1:0] rf_mem [SIZE] = INIT_VALS;
  logic [WIDTH-1:0] rf_out_q = '0;
  always @(posedge clk) begin
    if (rf_en && rf_wr)  rf_mem[rf_sel] <= rf_in;
    if (rf_en && !rf_wr) rf_out_q <= rf_mem[rf_sel];
  end
  assign rf_out = (RD_LAT == 0) ? rf_mem[rf_sel] : rf_out_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops plus protocol rules, sampled on the falling edge.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;
  logic [AW-1:0]    prev_sel   = '0;
  bit               have_prev  = 1'b0;
  int               prev_hs_cyc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (rf_en) rf_en_cnt <= rf_en_cnt + 1;
      if (rf_wr) begin
        check("wr_needs_en_and_load", {30'd0, rf_en, s_ready}, 32'd3);
        check("wr_expected", {31'd0, exp_wr_sel_q.size() > 0}, 32'd1);
        if (exp_wr_sel_q.size() > 0) begin
          check("wr_sel", {29'd0, rf_sel}, exp_wr_sel_q.pop_front());
          check("wr_data", {28'd0, rf_in}, {28'd0, exp_wr_data_q.pop_front()});
        end
      end
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, m_valid}, 32'd1);
        check("stall_data_stable", {28'd0, m_data}, {28'd0, prev_data});
        check("stall_sel_stable", {29'd0, rf_sel}, {29'd0, prev_sel});
      end
      if (m_valid && m_ready) begin
        check("dump_expected", {31'd0, exp_rd_q.size() > 0}, 32'd1);
        if (exp_rd_q.size() > 0)
          check("dump_data", {28'd0, m_data}, {28'd0, exp_rd_q.pop_front()});
        if (spacing_en) begin
          if (have_prev) check("dump_spacing", cyc - prev_hs_cyc, RD_LAT + 2);
          have_prev   <= 1'b1;
          prev_hs_cyc <= cyc;
        end
      end else if (!spacing_en) begin
        have_prev <= 1'b0;
      end
      if (done) begin
        check("done_expected", {31'd0, exp_done_q.size() > 0}, 32'd1);
        if (exp_done_q.size() > 0) void'(exp_done_q.pop_front());
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_sel   <= rf_sel;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    {31'd0, busy},    32'd0);
    check({tag, "_done"},    {31'd0, done},    32'd0);
    check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_rf_en"},   {31'd0, rf_en},   32'd0);
    check({tag, "_rf_wr"},   {31'd0, rf_wr},   32'd0);
    check({tag, "_m_data"},  {28'd0, m_data},  32'd0);
    check({tag, "_rf_in"},   {28'd0, rf_in},   32'd0);
    check({tag, "_rf_sel"},  {29'd0, rf_sel},  32'd0);
  endtask

  task automatic recover();
    rst_n = 1'b0;
    exp_wr_sel_q.delete();
    exp_wr_data_q.delete();
    exp_rd_q.delete();
    exp_done_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after START has been sampled.
  task automatic issue_start(input logic m, input int b, input int c);
    start     = 1'b1;
    mode      = m;
    dma_base  = AW'(b);
    dma_count = CW'(c);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc, output bit ok);
    ok   = 1'b0;
    dcyc = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (done) begin
        ok   = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    if (!ok) begin
      check("done_timeout", {31'd0, ok}, 32'd1);
      recover();
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_load(input int b, input int c, input int gap_pct,
                         input int abort_after, input bit check_timing);
    int n, limit, k, guard, first_cyc, dcyc;
    bit hs, ok;
    logic [WIDTH-1:0] words [$];
    n     = (c > SIZE) ? SIZE : c;
    limit = (abort_after >= 0 && abort_after < n) ? abort_after : n;
    for (int i = 0; i < n; i++)
      words.push_back((i < stim_words.size()) ? stim_words[i] : WIDTH'($urandom));
    stim_words.delete();
    for (int i = 0; i < limit; i++) begin
      exp_wr_sel_q.push_back((b + i) % SIZE);
      exp_wr_data_q.push_back(words[i]);
      model_mem[(b + i) % SIZE] = words[i];
    end
    if (limit == n) exp_done_q.push_back(1);
    issue_start(MODE_LOAD, b, c);
    if (n > 0) check("busy_after_start", {31'd0, busy}, 32'd1);
    k = 0; guard = 0; first_cyc = 0;
    while (k < limit && guard < BUDGET) begin
      s_valid = ($urandom_range(0, 99) >= gap_pct);
      s_data  = s_valid ? words[k] : WIDTH'($urandom);
      hs      = s_valid && s_ready;
      if (hs && k == 0) first_cyc = cyc;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    s_valid = 1'b0;
    if (k < limit) begin
      check("load_timeout", k, limit);
      recover();
      return;
    end
    if (limit < n) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_load_reset");
      repeat (2) begin
        @(negedge clk);
        check("no_done_in_reset", {31'd0, done}, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_writes_drained", exp_wr_sel_q.size(), 0);
      return;
    end
    wait_done(dcyc, ok);
    if (ok && check_timing) check("load_done_latency", dcyc - first_cyc, n);
    check("wr_queue_drained", exp_wr_sel_q.size(), 0);
  endtask

  task automatic do_dump(input int b, input int c, input int ready_pct, input int stall_word,
                         input int stall_len, input bit poke_start, input bit spacing);
    int n, k, guard, stall_left, dcyc;
    bit hs, ok;
    n = (c > SIZE) ? SIZE : c;
    for (int i = 0; i < n; i++) exp_rd_q.push_back(model_mem[(b + i) % SIZE]);
    exp_done_q.push_back(1);
    spacing_en = spacing;
    issue_start(MODE_DUMP, b, c);
    if (n > 0) check("busy_after_start", {31'd0, busy}, 32'd1);
    k = 0; guard = 0; stall_left = stall_len;
    while (k < n && guard < BUDGET) begin
      if (poke_start && guard == 2) begin
        start = 1'b1; mode = MODE_LOAD; dma_base = '0; dma_count = CW'(5);
      end else begin
        start = 1'b0;
      end
      if (m_valid && k == stall_word && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = ($urandom_range(0, 99) < ready_pct);
      end
      hs = m_valid && m_ready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    if (k < n) begin
      check("dump_timeout", k, n);
      spacing_en = 1'b0;
      recover();
      return;
    end
    wait_done(dcyc, ok);
    spacing_en = 1'b0;
    check("rd_queue_drained", exp_rd_q.size(), 0);
  endtask

  task automatic do_zero(input logic m);
    int s_cyc, dcyc, en_before;
    bit ok;
    exp_done_q.push_back(1);
    en_before = rf_en_cnt;
    s_cyc = cyc;
    issue_start(m, 3, 0);
    wait_done(dcyc, ok);
    if (ok) check("zero_done_latency", dcyc - s_cyc, 1);
    check("zero_no_rf_en", rf_en_cnt, en_before);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SIZE; i++) model_mem[i] = INIT_VALS[i];
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; dma_base = '0; dma_count = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full load of 1..8 with no gaps, then full dump at full rate.
    for (int i = 0; i < SIZE; i++) stim_words.push_back(WIDTH'(i + 1));
    do_load(0, 8, 0, -1, 1'b1);
    do_dump(0, 8, 100, -1, 0, 1'b0, 1'b1);

    // Wrap past the top index.
    stim_words = '{4'hA, 4'hB, 4'hC, 4'hD};
    do_load(6, 4, 0, -1, 1'b0);
    do_dump(6, 4, 100, -1, 0, 1'b0, 1'b0);

    // Sink backpressure on word 2, then source gaps.
    do_dump(0, 8, 100, 2, 5, 1'b0, 1'b0);
    do_load(2, 5, 50, -1, 1'b0);

    // Zero-length transfers in both modes.
    do_zero(MODE_LOAD);
    do_zero(MODE_DUMP);

    // Oversized count clamps to SIZE.
    do_load(3, 12, 20, -1, 1'b0);
    do_dump(3, 12, 70, -1, 0, 1'b0, 1'b0);

    // START while busy is ignored.
    do_dump(1, 6, 100, -1, 0, 1'b1, 1'b0);

    // Reset after three accepted words, then read everything back.
    stim_words = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    do_load(0, 8, 0, 3, 1'b0);
    do_dump(0, 8, 100, -1, 0, 1'b0, 1'b0);

    // Randomised transfers.
    for (int t = 0; t < 24; t++) begin
      int b, c;
      b = $urandom_range(0, SIZE - 1);
      c = $urandom_range(0, 15);
      if (c == 0) do_zero(1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 1) == 1) do_load(b, c, $urandom_range(0, 60), -1, 1'b0);
      else do_dump(b, c, $urandom_range(40, 100), -1, 0, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("final_done_queue_empty", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
